// File: rtl/pcm_interp_nch.sv
// rtl/pcm_interp_nch.sv - N-channel polyphase PCM interpolator sharing one coefficient ROM
module pcm_interp_nch #(
  parameter int NCH    = 2,
  parameter int DW     = 32,
  parameter int CW     = 32,
  parameter int PH_LEN = 128,
  parameter int SHIFT  = 27
) (
  input  logic                      mclk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                source_type,
  input  logic                      in_valid,
  input  logic [NCH*DW-1:0]         in_data,
  output logic                      in_ready,
  output logic [$clog2(PH_LEN)+2:0] coef_addr,
  input  logic [CW-1:0]             coef,
  output logic                      out_valid,
  output logic [NCH*DW-1:0]         out_data,
  output logic                      running,
  output logic                      ovf,
  output logic                      udr
);

  localparam int AW  = $clog2(PH_LEN);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;

  localparam logic [AW-1:0] JMAX  = AW'(PH_LEN - 1);
  localparam logic [AW-1:0] JTAP0 = AW'(2);

  // rounding constant and saturation limits, all in the widened accumulator domain
  localparam logic signed [ACW:0] HALF    = {{(ACW-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACW:0] SAT_MAX = {{(ACW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW:0] SAT_MIN = {{(ACW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  state_t state, state_nx;

  logic [AW-1:0] j;
  logic [AW-1:0] wptr;
  logic [AW-1:0] newest;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [2:0]    k;
  logic [2:0]    kmax;
  logic [2:0]    kpad;
  logic [1:0]    lsel;
  logic          ins_slot;
  logic          slot_end;
  logic          hist_we;

  logic signed [CW-1:0]  coef_s;
  logic signed [DW-1:0]  wdata   [NCH];
  logic signed [DW-1:0]  hist    [NCH][PH_LEN];
  logic signed [DW-1:0]  hist_q  [NCH];
  logic signed [PW-1:0]  prod    [NCH];
  logic signed [ACW-1:0] acc     [NCH];
  logic signed [ACW-1:0] acc_fin [NCH];
  logic signed [ACW:0]   rnd     [NCH];
  logic signed [ACW:0]   shd     [NCH];
  logic signed [DW-1:0]  sat     [NCH];
  logic [NCH-1:0]        sat_hit;

  // state register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state: en low always returns to IDLE on the following cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = CLEAR;
      CLEAR:   if (!en) state_nx = IDLE;
               else if (j == JMAX) state_nx = RUN;
      RUN:     if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // phase wrap value and coefficient phase field for the latched ratio
  always_comb begin
    kmax = 3'd0;
    kpad = 3'd0;
    case (lsel)
      2'b00: begin kmax = 3'd7; kpad = k;                 end
      2'b01: begin kmax = 3'd3; kpad = {1'b0, k[1:0]};    end
      2'b10: begin kmax = 3'd1; kpad = {2'b00, k[0]};     end
      default: begin kmax = 3'd0; kpad = 3'd0;            end
    endcase
  end

  assign running   = (state == RUN);
  assign ins_slot  = running && (j == '0) && (k == '0);
  assign slot_end  = running && (j == JMAX);
  assign in_ready  = ins_slot && in_valid;
  assign hist_we   = (state == CLEAR) || ins_slot;
  assign waddr     = (state == CLEAR) ? j : wptr;
  // at the insert cycle the sample being written is the newest; it is bypassed below
  assign newest    = ins_slot ? wptr : (wptr - AW'(1));
  assign raddr     = newest - j;
  assign coef_addr = {JMAX - j, kpad};
  assign coef_s    = coef;

  // history write data: zeros during CLEAR and on an underrun
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wdata[c] = (running && in_valid) ? in_data[c*DW +: DW] : '0;
    end
  end

  // slot/phase counters, write pointer and ratio latch
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      j    <= '0;
      k    <= '0;
      wptr <= '0;
      lsel <= 2'b00;
    end else if (!en) begin
      j <= '0;
      k <= '0;
    end else begin
      case (state)
        IDLE: begin
          j    <= '0;
          k    <= '0;
          lsel <= source_type;
        end
        CLEAR: begin
          j    <= j + AW'(1);
          wptr <= '0;
        end
        RUN: begin
          j <= j + AW'(1);
          if (slot_end) k <= (k == kmax) ? 3'd0 : k + 3'd1;
          if (ins_slot) wptr <= wptr + AW'(1);
        end
        default: j <= '0;
      endcase
    end
  end

  // per-channel history RAM with registered, write-first read
  always_ff @(posedge mclk) begin
    for (int c = 0; c < NCH; c++) begin
      if (hist_we) hist[c][waddr] <= wdata[c];
      hist_q[c] <= (hist_we && (waddr == raddr)) ? wdata[c] : hist[c][raddr];
    end
  end

  // registered multiply and per-slot accumulation of taps 0..PH_LEN-3
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        prod[c] <= PW'(hist_q[c]) * PW'(coef_s);
        if (!running || slot_end) acc[c] <= '0;
        else if (j >= JTAP0)      acc[c] <= acc_fin[c];
      end
    end
  end

  // final sum, round-half-up shift and saturation to the sample range
  always_comb begin
    sat_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      acc_fin[c] = acc[c] + ACW'(prod[c]);
      rnd[c]     = {acc_fin[c][ACW-1], acc_fin[c]} + HALF;
      shd[c]     = rnd[c] >>> SHIFT;
      if (shd[c] > SAT_MAX) begin
        sat[c]     = {1'b0, {(DW-1){1'b1}}};
        sat_hit[c] = 1'b1;
      end else if (shd[c] < SAT_MIN) begin
        sat[c]     = {1'b1, {(DW-1){1'b0}}};
        sat_hit[c] = 1'b1;
      end else begin
        sat[c]     = shd[c][DW-1:0];
      end
    end
  end

  // output frame register and sticky status flags
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
      udr       <= 1'b0;
    end else begin
      out_valid <= slot_end && en;
      if (slot_end && en) begin
        for (int c = 0; c < NCH; c++) begin
          out_data[c*DW +: DW] <= sat[c];
        end
        if (|sat_hit) ovf <= 1'b1;
      end
      if ((state == IDLE) && en) begin
        ovf <= 1'b0;
        udr <= 1'b0;
      end else if (ins_slot && !in_valid) begin
        udr <= 1'b1;
      end
    end
  end

endmodule
